systolic_array: RTL and testbench
=================================

SYSTOLIC_ARRAY -- requirements
Module: systolic_array

Interface
REQ-001 Parameter ROW_NUMBER, default 4: number of PE rows (≥1).
REQ-002 Parameter COLUMN_NUMBER, default 4: number of PE columns (≥1).
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 through  input  1  1 = drain mode (shift accumulators down); 0 = compute mode.
REQ-006 top_in  input  [7:0] x COLUMN_NUMBER (unpacked, index 0..COLUMN_NUMBER-1)  B operand per column; in drain mode, value shifted into row 0 accumulators.
REQ-007 left_in  input  [7:0] x ROW_NUMBER (unpacked, index 0..ROW_NUMBER-1)  A operand per row.
REQ-008 down_out  output  [7:0] x COLUMN_NUMBER (unpacked)  accumulator of bottom-row PE per column.

Function
REQ-009 Grid of ROW_NUMBER x COLUMN_NUMBER PEs, output-stationary; PE(r,c) holds a_reg, b_reg, acc, each 8-bit unsigned.
REQ-010 a_in(r,0)=left_in[r]; a_in(r,c>0)=a_reg(r,c-1); b_in(0,c)=top_in[c]; b_in(r>0,c)=b_reg(r-1,c).
REQ-011 Compute mode (through=0), per edge: acc <= acc + a_in*b_in; a_reg <= a_in; b_reg <= b_in.
REQ-012 Product and sum truncated modulo 256 (wrap) unless REQ-020 macro defined.
REQ-013 Drain mode (through=1), per edge: acc(0,c) <= top_in[c]; acc(r>0,c) <= acc(r-1,c); a_reg, b_reg <= 0; no MAC.
REQ-014 down_out[c] = acc(ROW_NUMBER-1,c) at all times, driven directly from the register, no extra latency.
REQ-015 Skew contract: A[i][k] presented on left_in[i] and B[k][j] on top_in[j] at edge i+1+k / j+1+k meet in PE(i,j) at edge i+j+k+1; C[i][j] final after edge i+j+K for inner dimension K.
REQ-016 After d drain edges, down_out holds original row ROW_NUMBER-1-d; rows emerge bottom-first.
REQ-017 Zero inputs in compute mode leave acc unchanged; idle cycles are harmless.
REQ-018 through toggling mid-stream is legal; each edge obeys REQ-011 or REQ-013 per current through value.

Reset
REQ-019 reset=1 at an edge clears every a_reg, b_reg, acc to 0 (down_out=0 next cycle); reset overrides through and may occur mid-operation.

Configuration
REQ-020 Macro SYSTOLIC_ARRAY_SATURATE_EN: when defined, each MAC computes the full 16-bit product plus acc and clamps to 255; when undefined, wrap-around per REQ-012.

Verification
REQ-021 4x4, reset 1 cycle, then all inputs 0 for 10 compute cycles -> down_out all 0.
REQ-022 A=[[1,2,3],[4,5,6]], B=[7,8,9]^T skewed per REQ-015, then through=1 -> down_out[0] shows row3=0, row2=0, row1=122, row0=50 on successive drain edges; other columns 0.
REQ-023 Single-pulse left_in[0]=3 and top_in[0]=5 at same edge -> acc(0,0)=15; drain with top_in=0 yields 15 on down_out[0] after 3 drain edges, then 0.
REQ-024 left_in[0]=16, top_in[0]=16 for one edge -> acc(0,0)=0 (wrap); with SYSTOLIC_ARRAY_SATURATE_EN -> 255.
REQ-025 Load nonzero accumulators, assert reset while through=1 -> all down_out 0 next cycle, drain yields only zeros.
REQ-026 Drain with top_in[c]=c+1 for 4 edges -> down_out[c]=c+1 after 4th edge (top values reach bottom).

Source files
------------

// File: rtl/systolic_array_if.sv
`default_nettype none
// ============================================================================
// Module      : systolic_array_if
// Description : Operand/result bundle for the output-stationary systolic array.
// Revision    : 1.0 - initial release
// ============================================================================
interface systolic_array_if #(
    parameter int ROW_NUMBER    = 4,
    parameter int COLUMN_NUMBER = 4
);
    logic       through;
    logic [7:0] top_in   [COLUMN_NUMBER];
    logic [7:0] left_in  [ROW_NUMBER];
    logic [7:0] down_out [COLUMN_NUMBER];

    modport master (
        output through,
        output top_in,
        output left_in,
        input  down_out
    );

    modport slave (
        input  through,
        input  top_in,
        input  left_in,
        output down_out
    );
endinterface
`default_nettype wire

// File: rtl/systolic_array.sv
`default_nettype none
// ============================================================================
// Module      : systolic_array
// Description : ROW_NUMBER x COLUMN_NUMBER output-stationary 8-bit MAC grid with
//               a drain mode that shifts accumulators down to the bottom row.
//               Define SYSTOLIC_ARRAY_SATURATE_EN to clamp MACs at 255.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_array #(
    parameter int ROW_NUMBER    = 4,
    parameter int COLUMN_NUMBER = 4
) (
    input  wire             clk,
    input  wire             reset,
    systolic_array_if.slave bus
);

    logic [7:0] r_a    [ROW_NUMBER][COLUMN_NUMBER];
    logic [7:0] r_b    [ROW_NUMBER][COLUMN_NUMBER];
    logic [7:0] r_acc  [ROW_NUMBER][COLUMN_NUMBER];
    logic [7:0] w_a_in [ROW_NUMBER][COLUMN_NUMBER];
    logic [7:0] w_b_in [ROW_NUMBER][COLUMN_NUMBER];

    function automatic logic [7:0] f_mac(
        input logic [7:0] acc,
        input logic [7:0] a,
        input logic [7:0] b
    );
`ifdef SYSTOLIC_ARRAY_SATURATE_EN
        logic [15:0] w_prod;
        logic [16:0] w_sum;
        w_prod = 16'(a) * 16'(b);
        w_sum  = 17'(acc) + 17'(w_prod);
        return (w_sum > 17'd255) ? 8'hFF : w_sum[7:0];
`else
        logic [7:0] w_prod;
        w_prod = a * b;
        return acc + w_prod;
`endif
    endfunction

    // Operands enter from the left/top edges and hop one PE per cycle.
    always_comb begin
        for (int r = 0; r < ROW_NUMBER; r++) begin
            w_a_in[r][0] = bus.left_in[r];
            for (int c = 1; c < COLUMN_NUMBER; c++) begin
                w_a_in[r][c] = r_a[r][c-1];
            end
        end
        for (int c = 0; c < COLUMN_NUMBER; c++) begin
            w_b_in[0][c] = bus.top_in[c];
            for (int r = 1; r < ROW_NUMBER; r++) begin
                w_b_in[r][c] = r_b[r-1][c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < ROW_NUMBER; r++) begin
                for (int c = 0; c < COLUMN_NUMBER; c++) begin
                    r_a[r][c]   <= 8'd0;
                    r_b[r][c]   <= 8'd0;
                    r_acc[r][c] <= 8'd0;
                end
            end
        end else if (bus.through) begin
            // Drain: accumulators form a per-column shift register, top_in feeds row 0.
            for (int c = 0; c < COLUMN_NUMBER; c++) begin
                r_acc[0][c] <= bus.top_in[c];
                for (int r = 1; r < ROW_NUMBER; r++) begin
                    r_acc[r][c] <= r_acc[r-1][c];
                end
            end
            for (int r = 0; r < ROW_NUMBER; r++) begin
                for (int c = 0; c < COLUMN_NUMBER; c++) begin
                    r_a[r][c] <= 8'd0;
                    r_b[r][c] <= 8'd0;
                end
            end
        end else begin
            for (int r = 0; r < ROW_NUMBER; r++) begin
                for (int c = 0; c < COLUMN_NUMBER; c++) begin
                    r_a[r][c]   <= w_a_in[r][c];
                    r_b[r][c]   <= w_b_in[r][c];
                    r_acc[r][c] <= f_mac(r_acc[r][c], w_a_in[r][c], w_b_in[r][c]);
                end
            end
        end
    end

    always_comb begin
        for (int c = 0; c < COLUMN_NUMBER; c++) begin
            bus.down_out[c] = r_acc[ROW_NUMBER-1][c];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_array
// Description : Self-checking bench for systolic_array (4x4); expectations come
//               from plain matrix products and a drain-order value history.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_array;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int KMAX = 8;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    int mat_a [ROWS][KMAX];
    int mat_b [KMAX][COLS];

    systolic_array_if #(.ROW_NUMBER(ROWS), .COLUMN_NUMBER(COLS)) bus ();

    systolic_array #(.ROW_NUMBER(ROWS), .COLUMN_NUMBER(COLS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_inputs();
        for (int c = 0; c < COLS; c++) bus.top_in[c] = 8'd0;
        for (int r = 0; r < ROWS; r++) bus.left_in[r] = 8'd0;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        bus.through = 1'b0;
        zero_inputs();
        tick();
        reset = 1'b0;
    endtask

    function automatic int mac_limit(input int sum);
`ifdef SYSTOLIC_ARRAY_SATURATE_EN
        return (sum > 255) ? 255 : sum;
`else
        return sum % 256;
`endif
    endfunction

    task automatic check_all_zero(input string tag);
        for (int c = 0; c < COLS; c++) check(tag, 32'(bus.down_out[c]), 32'd0);
    endtask

    // Feeds mat_a (ROWS x k) and mat_b (k x COLS) with the diagonal skew, then
    // drains and expects rows bottom-first followed by zeros.
    task automatic run_matmul(input int k, input string tag);
        int exp_c [ROWS][COLS];
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                int sum;
                sum = 0;
                for (int p = 0; p < k; p++) sum += mat_a[i][p] * mat_b[p][j];
                exp_c[i][j] = mac_limit(sum);
            end
        end
        do_reset();
        for (int t = 1; t <= ROWS + COLS + k; t++) begin
            for (int i = 0; i < ROWS; i++) begin
                int p;
                p = t - 1 - i;
                bus.left_in[i] = (p >= 0 && p < k) ? 8'(mat_a[i][p]) : 8'd0;
            end
            for (int j = 0; j < COLS; j++) begin
                int p;
                p = t - 1 - j;
                bus.top_in[j] = (p >= 0 && p < k) ? 8'(mat_b[p][j]) : 8'd0;
            end
            tick();
        end
        zero_inputs();
        bus.through = 1'b1;
        for (int d = 0; d <= ROWS; d++) begin
            if (d > 0) tick();
            for (int c = 0; c < COLS; c++) begin
                check($sformatf("%s_d%0d_c%0d", tag, d, c), 32'(bus.down_out[c]),
                      32'((d < ROWS) ? exp_c[ROWS-1-d][c] : 0));
            end
        end
        bus.through = 1'b0;
    endtask

    task automatic clear_mats();
        for (int i = 0; i < ROWS; i++) for (int p = 0; p < KMAX; p++) mat_a[i][p] = 0;
        for (int p = 0; p < KMAX; p++) for (int j = 0; j < COLS; j++) mat_b[p][j] = 0;
    endtask

    initial begin
        int pushed [$];
        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b1;
        bus.through = 1'b0;
        zero_inputs();

        do_reset();
        check_all_zero("reset");

        repeat (10) tick();
        check_all_zero("idle_zero");

        // Single pulse 3*5 in PE(0,0), then drain with zeros.
        bus.left_in[0] = 8'd3;
        bus.top_in[0]  = 8'd5;
        tick();
        zero_inputs();
        bus.through = 1'b1;
        for (int d = 1; d <= 4; d++) begin
            tick();
            check($sformatf("pulse_d%0d", d), 32'(bus.down_out[0]), 32'((d == 3) ? 15 : 0));
        end
        bus.through = 1'b0;

        // 16*16 overflows the 8-bit accumulator.
        do_reset();
        bus.left_in[0] = 8'd16;
        bus.top_in[0]  = 8'd16;
        tick();
        zero_inputs();
        bus.through = 1'b1;
        repeat (3) tick();
        check("overflow", 32'(bus.down_out[0]), 32'(mac_limit(256)));
        bus.through = 1'b0;

        // Worked example: A=[[1,2,3],[4,5,6]], B=[7,8,9]^T.
        clear_mats();
        mat_a[0][0] = 1; mat_a[0][1] = 2; mat_a[0][2] = 3;
        mat_a[1][0] = 4; mat_a[1][1] = 5; mat_a[1][2] = 6;
        mat_b[0][0] = 7; mat_b[1][0] = 8; mat_b[2][0] = 9;
        run_matmul(3, "example");

        for (int n = 0; n < 4; n++) begin
            int k;
            clear_mats();
            k = int'($urandom_range(1, KMAX));
            for (int i = 0; i < ROWS; i++)
                for (int p = 0; p < k; p++) mat_a[i][p] = int'($urandom_range(0, (n < 2) ? 15 : 255));
            for (int p = 0; p < k; p++)
                for (int j = 0; j < COLS; j++) mat_b[p][j] = int'($urandom_range(0, (n < 2) ? 15 : 255));
            run_matmul(k, $sformatf("rand%0d", n));
        end

        // Reset during drain wins over the shift.
        clear_mats();
        for (int i = 0; i < ROWS; i++) for (int j = 0; j < COLS; j++) begin
            mat_a[i][0] = i + 1;
            mat_b[0][j] = j + 2;
        end
        do_reset();
        for (int t = 1; t <= ROWS + COLS + 1; t++) begin
            for (int i = 0; i < ROWS; i++) bus.left_in[i] = (t - 1 - i == 0) ? 8'(mat_a[i][0]) : 8'd0;
            for (int j = 0; j < COLS; j++) bus.top_in[j] = (t - 1 - j == 0) ? 8'(mat_b[0][j]) : 8'd0;
            tick();
        end
        check("loaded_nonzero", 32'(bus.down_out[3]), 32'(4 * 5));
        zero_inputs();
        bus.through = 1'b1;
        reset       = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("reset_in_drain");
        repeat (4) tick();
        check_all_zero("drain_after_reset");
        bus.through = 1'b0;

        // top_in[c]=c+1 for four drain edges reaches the bottom row.
        do_reset();
        bus.through = 1'b1;
        for (int c = 0; c < COLS; c++) bus.top_in[c] = 8'(c + 1);
        repeat (4) tick();
        for (int c = 0; c < COLS; c++) check($sformatf("fill_c%0d", c), 32'(bus.down_out[c]), 32'(c + 1));
        bus.through = 1'b0;

        // Random through toggling: only drain edges advance the column history.
        do_reset();
        zero_inputs();
        for (int e = 0; e < 30; e++) begin
            int v;
            bus.through = 1'($urandom_range(0, 1));
            v = int'($urandom_range(0, 255));
            if (bus.through) begin
                for (int c = 0; c < COLS; c++) bus.top_in[c] = 8'((v + 37 * c) % 256);
                pushed.push_back(v);
            end else begin
                zero_inputs();
            end
            tick();
            for (int c = 0; c < COLS; c++) begin
                int exp_v;
                exp_v = (pushed.size() >= ROWS) ? (pushed[pushed.size() - ROWS] + 37 * c) % 256 : 0;
                check($sformatf("toggle_e%0d_c%0d", e, c), 32'(bus.down_out[c]), 32'(exp_v));
            end
        end
        bus.through = 1'b0;
        zero_inputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
